// File: rtl/apb_bridge_err_pkg.sv
// Shared types for the AHB-Lite to APB4 bridge: FSM states and AHB transfer encodings.
package apb_bridge_err_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never start one.
   function automatic logic htrans_active(input logic [1:0] t);
      return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
   endfunction

endpackage

// File: rtl/bridge_timer.sv
// Saturating PREADY-wait counter; tc flags the last allowed wait cycle of an ACCESS.
module bridge_timer #(
   parameter int TOW     = 8,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [TOW-1:0] TC_VAL = (TIMEOUT == 0) ? '0 : TOW'(TIMEOUT - 1);

   logic [TOW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + TOW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zero TIMEOUT disables the abort entirely.
   assign tc = (TIMEOUT != 0) && en && (cnt_q == TC_VAL);

endmodule

// File: rtl/apb_bridge_err.sv
// AHB-Lite to APB4 bridge over NSEL slots with PSLVERR-to-ERROR mapping and PREADY timeout.
module apb_bridge_err
   import apb_bridge_err_pkg::*;
#(
   parameter int NSEL    = 8,
   parameter int ADDRW   = 32,
   parameter int DATAW   = 64,
   parameter int TOW     = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic [NSEL-1:0]         HSEL,
   input  logic [ADDRW-1:0]        HADDR,
   input  logic                    HWRITE,
   input  logic [1:0]              HTRANS,
   input  logic                    HREADY,
   input  logic [DATAW-1:0]        HWDATA,
   input  logic [DATAW/8-1:0]      HWSTRB,
   output logic [DATAW-1:0]        HRDATA,
   output logic                    HREADYOUT,
   output logic                    HRESP,
   output logic [NSEL-1:0]         PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDRW-1:0]        PADDR,
   output logic [DATAW-1:0]        PWDATA,
   output logic [DATAW/8-1:0]      PSTRB,
   input  logic [NSEL-1:0]         PREADY,
   input  logic [NSEL*DATAW-1:0]   PRDATA,
   input  logic [NSEL-1:0]         PSLVERR,
   output logic                    TimeoutErr
);

   localparam int IDXW = (NSEL > 1) ? $clog2(NSEL) : 1;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [NSEL-1:0]  psel_q, psel_d;
   logic             penable_q, penable_d;
   logic             pwrite_q, pwrite_d;
   logic [ADDRW-1:0] paddr_q, paddr_d;
   logic             hready_q, hready_d;
   logic             hresp_q, hresp_d;
   logic             tout_q, tout_d;

   logic [IDXW-1:0]  sel_idx;
   logic             accept;
   logic             sel_ready;
   logic             sel_err;
   logic             complete;
   logic             start;
   logic             timer_en;
   logic             timer_tc;

   // Priority encoder: scanning downward leaves the lowest set HSEL bit as the winner.
   always_comb begin
      sel_idx = '0;
      for (int i = NSEL - 1; i >= 0; i--) begin
         if (HSEL[i]) begin
            sel_idx = IDXW'(i);
         end
      end
   end

   assign accept    = HREADY && (|HSEL) && htrans_active(HTRANS);
   assign sel_ready = PREADY[idx_q];
   assign sel_err   = PSLVERR[idx_q];
   assign complete  = (state_q == ST_ACCESS) && sel_ready && !sel_err;
   assign start     = accept && ((state_q == ST_IDLE) || (state_q == ST_ERR2) || complete);
   assign timer_en  = (state_q == ST_ACCESS) && !sel_ready;

   bridge_timer #(
      .TOW     (TOW),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .clr   (start),
      .en    (timer_en),
      .tc    (timer_tc)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      hready_d  = hready_q;
      hresp_d   = hresp_q;
      tout_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
         end
         ST_SETUP: begin
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
         end
         ST_ACCESS: begin
            if (sel_ready) begin
               psel_d    = '0;
               penable_d = 1'b0;
               if (sel_err) begin
                  state_d  = ST_ERR1;
                  hresp_d  = 1'b1;
                  hready_d = 1'b0;
               end else begin
                  state_d  = ST_IDLE;
                  hready_d = 1'b1;
               end
            end else if (timer_tc) begin
               state_d   = ST_ERR1;
               psel_d    = '0;
               penable_d = 1'b0;
               hresp_d   = 1'b1;
               tout_d    = 1'b1;
            end
         end
         ST_ERR1: begin
            state_d  = ST_ERR2;
            hready_d = 1'b1;
         end
         ST_ERR2: begin
            state_d = ST_IDLE;
            hresp_d = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new address phase overrides whatever the current state would settle into.
      if (start) begin
         state_d         = ST_SETUP;
         idx_d           = sel_idx;
         paddr_d         = HADDR;
         pwrite_d        = HWRITE;
         psel_d          = '0;
         psel_d[sel_idx] = 1'b1;
         penable_d       = 1'b0;
         hready_d        = 1'b0;
         hresp_d         = 1'b0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         hready_q  <= 1'b1;
         hresp_q   <= 1'b0;
         tout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         hready_q  <= hready_d;
         hresp_q   <= hresp_d;
         tout_q    <= tout_d;
      end
   end

   // The completing ACCESS cycle answers the AHB side combinationally from PREADY.
   assign HREADYOUT  = hready_q || complete;
   assign HRDATA     = complete ? PRDATA[idx_q*DATAW +: DATAW] : '0;
   assign HRESP      = hresp_q;
   assign PSEL       = psel_q;
   assign PENABLE    = penable_q;
   assign PWRITE     = pwrite_q;
   assign PADDR      = paddr_q;
   assign PWDATA     = HWDATA;
   assign PSTRB      = (pwrite_q && (|psel_q)) ? HWSTRB : '0;
   assign TimeoutErr = tout_q;

endmodule

// File: doc/apb_bridge_err.md
Name: apb_bridge_err

Overview:
Parametrised AHB-Lite to APB4 bridge for the uncore peripheral region, generalised to NSEL peripheral slots. Adds per-slave PSLVERR mapping to the two-cycle AHB ERROR response. Adds a programmable-depth PREADY timeout so a hung peripheral cannot lock the bus. Sits between the uncore address decoder's HSEL vector and the APB peripherals (CLINT, PLIC, GPIO, UART, SPI, SDC, video, ...).

Parameters:
NSEL, 8, number of APB slave slots (1..16)
ADDRW, 32, PADDR width; PADDR = HADDR[ADDRW-1:0]
DATAW, 64, AHB/APB data width (32 or 64)
TOW, 8, timeout counter width
TIMEOUT, 255, ACCESS cycles without PREADY before abort; 0 disables timeout

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
HSEL  in  NSEL  one-hot slot select from address decoder (address phase)
HADDR  in  ADDRW  address-phase address
HWRITE  in  1  address-phase write
HTRANS  in  2  AHB transfer type
HREADY  in  1  global bus HREADY (qualifies address phase)
HWDATA  in  DATAW  data-phase write data, held by master during wait states
HWSTRB  in  DATAW/8  data-phase byte strobes
HRDATA  out  DATAW  read data to AHB mux
HREADYOUT  out  1  this slave's ready
HRESP  out  1  1 = ERROR
PSEL  out  NSEL  APB selects
PENABLE  out  1  APB enable
PWRITE  out  1  APB write
PADDR  out  ADDRW  APB address
PWDATA  out  DATAW  APB write data
PSTRB  out  DATAW/8  APB strobes, 0 on reads
PREADY  in  NSEL  per-slave ready
PRDATA  in  NSEL*DATAW  per-slave read data, packed [NSEL-1:0][DATAW-1:0]
PSLVERR  in  NSEL  per-slave error
TimeoutErr  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async, any state): state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, HREADYOUT=1, HRESP=0, TimeoutErr=0, counter=0. In-flight transfer is dropped; no response owed.
- Accept = HREADY & |HSEL & HTRANS[1]. On accept, register slot index, HADDR, HWRITE; next state SETUP.
- If HSEL is not one-hot, the lowest set index wins.
- States: IDLE, SETUP, ACCESS, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0, PSEL=0.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0, HREADYOUT=0. Then ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1. PWDATA=HWDATA and PSTRB=HWSTRB (write) or 0 (read), driven combinationally.
- ACCESS, PREADY[idx]=1 and PSLVERR[idx]=0: HREADYOUT=1, HRDATA=PRDATA[idx] in the same cycle. Next state is SETUP if accept, else IDLE.
- ACCESS, PREADY[idx]=1 and PSLVERR[idx]=1: HREADYOUT=0, HRESP=0; next state ERR1.
- ACCESS, PREADY[idx]=0: counter increments (saturating). When counter==TIMEOUT-1 and TIMEOUT!=0:
  - drop PSEL/PENABLE next cycle;
  - pulse TimeoutErr;
  - next state ERR1.
- Counter clears on entering SETUP.
- ERR1: HRESP=1, HREADYOUT=0, PSEL=0. ERR2: HRESP=1, HREADYOUT=1, PSEL=0. From ERR2: accept -> SETUP, else IDLE. An accept seen during ERR1 is ignored, since HREADY is low.
- Minimum latency: 2 data-phase cycles (1 wait state). Back-to-back transfers have no IDLE gap.
- PSLVERR/PREADY/PRDATA of non-selected slots are ignored.
- HRDATA is 0 except in the completing ACCESS cycle.

Decomposition:
- Shared package: state enum (IDLE, SETUP, ACCESS, ERR1, ERR2) and HTRANS encodings (HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10).
- Sub-module bridge_timer: TOW-bit saturating counter with clear/enable and terminal-count compare to TIMEOUT, output tc.
- One-hot-to-index priority encoder inline.

Test Plan:
- Read slot 2, PRDATA[2]=64'hDEAD_BEEF_0123_4567, PREADY=1 immediately -> PSEL=8'h04 for SETUP+ACCESS, HREADYOUT low 1 cycle, HRDATA=64'hDEAD_BEEF_0123_4567, PSTRB=0.
- Write slot 5, HWDATA=64'h55, HWSTRB=8'h01, PREADY low 3 ACCESS cycles -> PWRITE=1, PWDATA=64'h55, PSTRB=8'h01 stable; 4 wait states; PSEL=8'h20.
- Read slot 1 with PSLVERR[1]=1 at PREADY -> ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), then IDLE.
- TIMEOUT=4, PREADY stuck 0 on slot 0 -> after 4 ACCESS cycles: TimeoutErr pulses once, PSEL=0, two-cycle ERROR.
- Back-to-back write slot 3 then read slot 7, with the second address phase in the completing cycle -> SETUP follows immediately; PSEL 8'h08 then 8'h80.
- HRESETn asserted mid-ACCESS -> same cycle (async): PSEL=0, PENABLE=0, HREADYOUT=1; after release, a new read completes normally.
